// File: rtl/univ_reg_pkg.sv
// Shared operation codes for the universal register family.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package univ_reg_pkg;

    // 3-bit operation select; the all-ones code is reserved and acts as HOLD.
    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_SHR  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_ROR  = 3'b101;
    localparam logic [2:0] MODE_CLR  = 3'b110;
    localparam logic [2:0] MODE_RSV  = 3'b111;

endpackage

// File: rtl/univ_shift_reg_n_sat_cnt.sv
// Saturating up-counter with synchronous clear and an at-max flag.
// Latency: count updates one cycle after inc/clr; max_out is combinational on the register.
// Backpressure: none; increments requested at MAX are absorbed (counter never wraps).
module sat_cnt_n #(
    parameter int MAX = 8,
    parameter int CW  = $clog2(MAX + 1)
) (
    input  logic          clk_in,
    input  logic          rst_n_in,
    input  logic          clr_in,
    input  logic          inc_in,
    output logic [CW-1:0] cnt_out,
    output logic          max_out
);

    localparam logic [CW-1:0] MAX_C = CW'(MAX);

    // Clear has priority over increment; increment stops once MAX is reached.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cnt_out <= '0;
        end else if (clr_in) begin
            cnt_out <= '0;
        end else if (inc_in && (cnt_out != MAX_C)) begin
            cnt_out <= cnt_out + CW'(1);
        end
    end

    assign max_out = (cnt_out == MAX_C);

endmodule

// File: rtl/univ_shift_reg_n.sv
// W-bit universal register: hold/load/shift/rotate/clear with a saturating shift counter.
// Latency: one cycle from mode_in sampled at the rising edge to q_out/cnt_out; done_out follows cnt_out.
// Backpressure: none; a new operation is accepted every cycle.
module univ_shift_reg_n
    import univ_reg_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}},
    localparam int              CW      = $clog2(WIDTH + 1)
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic [2:0]       mode_in,
    input  logic [WIDTH-1:0] d_in,
    input  logic             si_in,
    output logic [WIDTH-1:0] q_out,
    output logic [CW-1:0]    cnt_out,
    output logic             done_out
);

    logic cnt_clr;
    logic cnt_inc;

    // LOAD and CLR restart the shift count; every shift or rotate advances it.
    always_comb begin
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        case (mode_in)
            MODE_LOAD, MODE_CLR:                     cnt_clr = 1'b1;
            MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR:  cnt_inc = 1'b1;
            default: ;
        endcase
    end

    // Shift datapath; CLR forces zero rather than RST_VAL, and the reserved code holds.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            q_out <= RST_VAL;
        end else begin
            case (mode_in)
                MODE_LOAD: q_out <= d_in;
                MODE_SHL:  q_out <= {q_out[WIDTH-2:0], si_in};
                MODE_SHR:  q_out <= {si_in, q_out[WIDTH-1:1]};
                MODE_ROL:  q_out <= {q_out[WIDTH-2:0], q_out[WIDTH-1]};
                MODE_ROR:  q_out <= {q_out[0], q_out[WIDTH-1:1]};
                MODE_CLR:  q_out <= '0;
                default:   q_out <= q_out;
            endcase
        end
    end

    sat_cnt_n #(
        .MAX (WIDTH),
        .CW  (CW)
    ) u_sat_cnt (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .clr_in   (cnt_clr),
        .inc_in   (cnt_inc),
        .cnt_out  (cnt_out),
        .max_out  (done_out)
    );

endmodule

// File: tb/tb_univ_shift_reg_n.sv
module tb_univ_shift_reg_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 8-bit instance
    logic       rst_n;
    logic [2:0] mode;
    logic [7:0] d;
    logic       si;
    logic [7:0] q;
    logic [3:0] cnt;
    logic       done;

    // 2-bit instance with non-zero reset value
    logic       rst2_n;
    logic [2:0] mode2;
    logic [1:0] d2;
    logic       si2;
    logic [1:0] q2;
    logic [1:0] cnt2;
    logic       done2;

    univ_shift_reg_n #(.WIDTH(8), .RST_VAL(8'h00)) dut8 (
        .clk_in(clk), .rst_n_in(rst_n), .mode_in(mode), .d_in(d), .si_in(si),
        .q_out(q), .cnt_out(cnt), .done_out(done)
    );

    univ_shift_reg_n #(.WIDTH(2), .RST_VAL(2'b10)) dut2 (
        .clk_in(clk), .rst_n_in(rst2_n), .mode_in(mode2), .d_in(d2), .si_in(si2),
        .q_out(q2), .cnt_out(cnt2), .done_out(done2)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    // reference state: register value and shift count as plain integers
    int mq, mc, mq2, mc2;

    // Behavioural model of one clock edge, using arithmetic on the integer value.
    function automatic void model(input int w, input int mo, input int dd, input int s,
                                  inout int qq, inout int cc);
        int full;
        int top;
        full = 1 << w;
        top  = 1 << (w - 1);
        case (mo)
            1: begin qq = dd % full;                           cc = 0; end
            2: begin qq = (qq * 2) % full + s;                 cc = (cc < w) ? cc + 1 : w; end
            3: begin qq = qq / 2 + s * top;                    cc = (cc < w) ? cc + 1 : w; end
            4: begin qq = (qq * 2) % full + qq / top;          cc = (cc < w) ? cc + 1 : w; end
            5: begin qq = qq / 2 + (qq % 2) * top;             cc = (cc < w) ? cc + 1 : w; end
            6: begin qq = 0;                                   cc = 0; end
            default: ;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag);
        chk({tag, " q"},    32'(q),    32'(mq));
        chk({tag, " cnt"},  32'(cnt),  32'(mc));
        chk({tag, " done"}, 32'(done), 32'(mc == 8));
    endtask

    task automatic chk2(input string tag);
        chk({tag, " q2"},    32'(q2),    32'(mq2));
        chk({tag, " cnt2"},  32'(cnt2),  32'(mc2));
        chk({tag, " done2"}, 32'(done2), 32'(mc2 == 2));
    endtask

    task automatic step8(input logic [2:0] m, input logic [7:0] dv, input logic s, input string tag);
        mode = m; d = dv; si = s;
        @(posedge clk);
        #1;
        model(8, int'(m), int'(dv), int'(s), mq, mc);
        chk8(tag);
    endtask

    task automatic step2(input logic [2:0] m, input logic [1:0] dv, input logic s, input string tag);
        mode2 = m; d2 = dv; si2 = s;
        @(posedge clk);
        #1;
        model(2, int'(m), int'(dv), int'(s), mq2, mc2);
        chk2(tag);
    endtask

    initial begin
        rst_n = 1'b0; mode = 3'd0; d = 8'h00; si = 1'b0;
        rst2_n = 1'b0; mode2 = 3'd0; d2 = 2'b00; si2 = 1'b0;
        mq = 0; mc = 0; mq2 = 2; mc2 = 0;
        #12;
        chk8("reset");
        chk2("reset2");
        chk("reset2 q const", 32'(q2), 32'h2);
        @(negedge clk);
        rst_n = 1'b1;

        // LOAD A5 then three SHL with si=1
        step8(3'b001, 8'hA5, 1'b0, "load a5");
        step8(3'b010, 8'h00, 1'b1, "shl1");  chk("shl1 const", 32'(q), 32'h4B);
        step8(3'b010, 8'h00, 1'b1, "shl2");  chk("shl2 const", 32'(q), 32'h97);
        step8(3'b010, 8'h00, 1'b1, "shl3");  chk("shl3 const", 32'(q), 32'h2F);
        chk("shl3 cnt const", 32'(cnt), 32'd3);

        // async reset between edges during SHL
        mode = 3'b010; si = 1'b1;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        mq = 0; mc = 0;
        chk8("async rst");
        #1 rst_n = 1'b1;
        step8(3'b001, 8'h3C, 1'b0, "load after rst");
        chk("load after rst const", 32'(q), 32'h3C);

        // LOAD A5 then eight ROR returns to A5, ninth gives D2
        step8(3'b001, 8'hA5, 1'b0, "load a5 b");
        for (int i = 0; i < 8; i++) step8(3'b101, 8'h00, 1'b0, "ror");
        chk("ror8 const", 32'(q), 32'hA5);
        chk("ror8 done const", 32'(done), 32'd1);
        step8(3'b101, 8'h00, 1'b0, "ror9");
        chk("ror9 const", 32'(q), 32'hD2);
        chk("ror9 cnt const", 32'(cnt), 32'd8);

        // LOAD 81, SHR x2 with si=0, ROL
        step8(3'b001, 8'h81, 1'b1, "load 81");
        step8(3'b011, 8'hFF, 1'b0, "shr1"); chk("shr1 const", 32'(q), 32'h40);
        step8(3'b011, 8'hFF, 1'b0, "shr2"); chk("shr2 const", 32'(q), 32'h20);
        step8(3'b100, 8'hFF, 1'b1, "rol");  chk("rol const", 32'(q), 32'h40);
        chk("rol cnt const", 32'(cnt), 32'd3);

        // q=FF cnt=5, then HOLD/reserved keep state, CLR zeroes
        step8(3'b001, 8'hFF, 1'b0, "load ff");
        for (int i = 0; i < 5; i++) step8(3'b010, 8'h00, 1'b1, "shl ones");
        for (int i = 0; i < 3; i++) step8(3'b000, 8'h5A, 1'b0, "hold");
        for (int i = 0; i < 3; i++) step8(3'b111, 8'h33, 1'b1, "rsv");
        chk("hold q const", 32'(q), 32'hFF);
        chk("hold cnt const", 32'(cnt), 32'd5);
        step8(3'b110, 8'hEE, 1'b1, "clr");
        chk("clr const", 32'(q), 32'h00);

        // randomized operations with occasional async reset
        for (int i = 0; i < 300; i++) begin
            step8(3'($urandom_range(0, 7)), 8'($urandom), 1'($urandom), "rand8");
            if ($urandom_range(0, 31) == 0) begin
                #2 rst_n = 1'b0;
                #1;
                mq = 0; mc = 0;
                chk8("rand8 rst");
                rst_n = 1'b1;
            end
        end

        // 2-bit instance
        @(negedge clk);
        rst2_n = 1'b1;
        step2(3'b010, 2'b00, 1'b1, "w2 shl1"); chk("w2 shl1 const", 32'(q2), 32'h1);
        step2(3'b010, 2'b00, 1'b1, "w2 shl2"); chk("w2 shl2 const", 32'(q2), 32'h3);
        chk("w2 done const", 32'(done2), 32'd1);
        step2(3'b110, 2'b11, 1'b1, "w2 clr");  chk("w2 clr const", 32'(q2), 32'h0);
        for (int i = 0; i < 150; i++) begin
            step2(3'($urandom_range(0, 7)), 2'($urandom), 1'($urandom), "rand2");
            if ($urandom_range(0, 31) == 0) begin
                #2 rst2_n = 1'b0;
                #1;
                mq2 = 2; mc2 = 0;
                chk2("rand2 rst");
                rst2_n = 1'b1;
            end
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
